row_mem_responder: RTL and testbench

ROW_MEM_RESPONDER -- requirements
Module: row_mem_responder

---
 rtl/row_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_row_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/row_mem_responder.sv
// Burst memory responder: latency-delayed reads, paced acknowledges and refresh stalls.
// Defining PROTO_CHECK_EN adds a sticky protocol-error flag; otherwise protoError is tied low.
module row_mem_responder #(
  parameter int READ_LATENCY   = 3,
  parameter int REFRESH_CYCLES = 8,
  parameter int MEM_ADDR_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [23:0] readAddress,
  output logic        readAcknowledge,
  output logic [15:0] readData,
  input  logic        write,
  input  logic [23:0] writeAddress,
  input  logic [15:0] writeData,
  output logic        writeAcknowledge,
  input  logic        refresh,
  output logic        protoError
);
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {IDLE, RD_LAT, XFER, GAP, REFRESH} state_t;

  state_t                r_state;
  logic [DATA_W-1:0]     r_mem [2**MEM_ADDR_W];
  logic [MEM_ADDR_W-1:0] r_ptr;
  logic                  r_dir_wr;
  logic                  r_busy;
  logic                  r_ref_pend;
  logic                  r_rack;
  logic                  r_wack;
  logic [DATA_W-1:0]     r_rdata;
  logic [3:0]            r_lat_cnt;
  logic [7:0]            r_ref_cnt;

  logic   w_ref_pend;
  logic   w_req_active;
  logic   w_take_ref;
  logic   w_ref_done;
  state_t w_resume;
  logic   w_unused;

  // A refresh seen in the deciding cycle is serviced at once rather than a word later.
  assign w_ref_pend   = r_ref_pend | refresh;
  assign w_req_active = r_dir_wr ? write : read;
  assign w_ref_done   = (r_state == REFRESH) && (r_ref_cnt == 8'(REFRESH_CYCLES - 1));
  assign w_take_ref   = w_ref_pend && ((r_state == IDLE) || (r_state == GAP) || w_ref_done);
  assign w_unused     = ^{readAddress[23:MEM_ADDR_W], writeAddress[23:MEM_ADDR_W]};

  always_comb begin
    w_resume = IDLE;
    if (w_ref_pend)
      w_resume = REFRESH;
    else if (r_busy && w_req_active)
      w_resume = XFER;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_dir_wr   <= 1'b0;
      r_busy     <= 1'b0;
      r_ref_pend <= 1'b0;
      r_rack     <= 1'b0;
      r_wack     <= 1'b0;
      r_rdata    <= '0;
      r_lat_cnt  <= '0;
      r_ref_cnt  <= '0;
    end else begin
      r_rack     <= 1'b0;
      r_wack     <= 1'b0;
      r_ref_pend <= w_take_ref ? 1'b0 : w_ref_pend;
      case (r_state)
        IDLE: begin
          if (w_ref_pend) begin
            r_state   <= REFRESH;
            r_ref_cnt <= '0;
          end else if (write) begin
            r_dir_wr <= 1'b1;
            r_busy   <= 1'b1;
            r_ptr    <= writeAddress[MEM_ADDR_W-1:0];
            r_state  <= XFER;
          end else if (read) begin
            r_dir_wr  <= 1'b0;
            r_busy    <= 1'b1;
            r_ptr     <= readAddress[MEM_ADDR_W-1:0];
            r_lat_cnt <= '0;
            r_state   <= (READ_LATENCY == 1) ? XFER : RD_LAT;
          end
        end
        RD_LAT: begin
          if (!read) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_lat_cnt == 4'(READ_LATENCY - 2)) begin
            r_state <= XFER;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        XFER: begin
          if (r_dir_wr) begin
            r_wack <= 1'b1;
          end else begin
            r_rack  <= 1'b1;
            r_rdata <= r_mem[r_ptr];
          end
          r_ptr   <= r_ptr + MEM_ADDR_W'(1);
          r_state <= GAP;
        end
        GAP: begin
          r_state   <= w_resume;
          r_ref_cnt <= '0;
          if (w_resume == IDLE) r_busy <= 1'b0;
        end
        REFRESH: begin
          if (w_ref_done) begin
            r_state   <= w_resume;
            r_ref_cnt <= '0;
            if (w_resume == IDLE) r_busy <= 1'b0;
          end else begin
            r_ref_cnt <= r_ref_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage has no reset so contents survive an rst pulse.
  always_ff @(posedge clk) begin
    if ((r_state == XFER) && r_dir_wr)
      r_mem[r_ptr] <= writeData;
  end

  assign readAcknowledge  = r_rack;
  assign writeAcknowledge = r_wack;
  assign readData         = r_rdata;

`ifdef PROTO_CHECK_EN
  logic       w_accept;
  logic [6:0] r_wcnt;
  logic       r_perr;

  assign w_accept = (r_state == IDLE) && !w_ref_pend && (write || read);

  // Word counter saturates past 65 so a very long burst cannot wrap and hide the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
      r_perr <= 1'b0;
    end else begin
      if (w_accept)
        r_wcnt <= '0;
      else if ((r_state == XFER) && (r_wcnt != 7'd65))
        r_wcnt <= r_wcnt + 7'd1;
      if ((read && write) || ((r_state == XFER) && (r_wcnt == 7'd64)))
        r_perr <= 1'b1;
    end
  end

  assign protoError = r_perr;
`else
  assign protoError = 1'b0;
`endif

endmodule

// File: tb/tb_row_mem_responder.sv
// Scoreboard bench for row_mem_responder: stimulus queues expected acks, a monitor pops and compares.
module tb_row_mem_responder;
  localparam int LAT = 3;
  localparam int RC  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic [23:0] readAddress = '0;
  logic        readAcknowledge;
  logic [15:0] readData;
  logic        write = 1'b0;
  logic [23:0] writeAddress = '0;
  logic [15:0] writeData = '0;
  logic        writeAcknowledge;
  logic        refresh = 1'b0;
  logic        protoError;

  row_mem_responder #(
    .READ_LATENCY  (LAT),
    .REFRESH_CYCLES(RC),
    .MEM_ADDR_W    (10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read            (read),
    .readAddress     (readAddress),
    .readAcknowledge (readAcknowledge),
    .readData        (readData),
    .write           (write),
    .writeAddress    (writeAddress),
    .writeData       (writeData),
    .writeAcknowledge(writeAcknowledge),
    .refresh         (refresh),
    .protoError      (protoError)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_ack  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (readAcknowledge || writeAcknowledge) begin
        n_ack++;
        check("ack_overlap", {31'd0, readAcknowledge & writeAcknowledge}, 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got rd=%0b wr=%0b required no acknowledge (cycle %0d)",
                   readAcknowledge, writeAcknowledge, cyc);
        end else begin
          e = exp_q.pop_front();
          check("ack_dir_is_write", {31'd0, writeAcknowledge}, {31'd0, e.is_wr});
          if (!e.is_wr) check("read_data", {16'd0, readData}, {16'd0, e.data});
          check("ack_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_acks(input int base, input int n);
    int t = 0;
    while ((n_ack - base) < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ack_count_reached", n_ack - base, n);
  endtask

  task automatic write_burst(input logic [23:0] addr, input logic [15:0] base_d, input int n,
                             input bit also_read, input bit rst_at_end);
    int   acc;
    int   b;
    exp_t e;
    @(negedge clk);
    acc = cyc + 1;
    for (int k = 0; k < n; k++) begin
      e.is_wr = 1'b1;
      e.data  = base_d + 16'(k);
      e.cyc   = acc + 1 + 2 * k;
      exp_q.push_back(e);
    end
    b            = n_ack;
    writeAddress = addr;
    writeData    = base_d;
    write        = 1'b1;
    if (also_read) begin
      readAddress = 24'h000300;
      read        = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      wait_acks(b, k + 1);
      if (k == n - 1) begin
        if (rst_at_end) begin
          rst = 1'b1;
          #1;
          check("rst_wack_zero", {31'd0, writeAcknowledge}, 32'd0);
          check("rst_rack_zero", {31'd0, readAcknowledge}, 32'd0);
          check("rst_rdata_zero", {16'd0, readData}, 32'd0);
          check("rst_perr_zero", {31'd0, protoError}, 32'd0);
        end
        write = 1'b0;
        read  = 1'b0;
      end else begin
        @(posedge clk);
        #1;
        writeData = base_d + 16'(k + 1);
      end
    end
    if (rst_at_end) begin
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic read_burst(input logic [23:0] addr, input logic [15:0] base_d, input int n,
                            input int ref_after);
    int   acc;
    int   b;
    exp_t e;
    @(negedge clk);
    acc = cyc + 1;
    for (int k = 0; k < n; k++) begin
      e.is_wr = 1'b0;
      e.data  = base_d + 16'(k);
      e.cyc   = acc + LAT + 2 * k + (((ref_after > 0) && (k >= ref_after)) ? RC : 0);
      exp_q.push_back(e);
    end
    b           = n_ack;
    readAddress = addr;
    read        = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_acks(b, k + 1);
      if (k == n - 1) begin
        read = 1'b0;
      end else if (k + 1 == ref_after) begin
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    int b;
    logic exp_perr;
`ifdef PROTO_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_rack", {31'd0, readAcknowledge}, 32'd0);
    check("reset_wack", {31'd0, writeAcknowledge}, 32'd0);
    check("reset_rdata", {16'd0, readData}, 32'd0);
    check("reset_perr", {31'd0, protoError}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 40-word write row, then plain readback, then readback with a refresh after word 18.
    write_burst(24'h000040, 16'h1000, 40, 1'b0, 1'b0);
    read_burst(24'h000040, 16'h1000, 40, 0);
    read_burst(24'h000040, 16'h1000, 40, 18);

    // read and write together from IDLE: serviced as a write to writeAddress.
    write_burst(24'h000200, 16'hA000, 3, 1'b1, 1'b0);
    check("perr_after_both", {31'd0, protoError}, {31'd0, exp_perr});
    repeat (5) @(negedge clk);
    check("perr_sticky", {31'd0, protoError}, {31'd0, exp_perr});
    read_burst(24'h000200, 16'hA000, 3, 0);

    // Reset after the 10th write acknowledge; the stored words survive.
    write_burst(24'h000040, 16'h5000, 10, 1'b0, 1'b1);
    check("perr_after_rst", {31'd0, protoError}, 32'd0);
    read_burst(24'h000040, 16'h5000, 10, 0);

    // Burst from 1020 wraps after 4 words; upper address bits ignored.
    write_burst(24'hABC3FC, 16'h7000, 6, 1'b0, 1'b0);
    read_burst(24'h000000, 16'h7004, 2, 0);
    read_burst(24'h0003FC, 16'h7000, 6, 0);

    // Read dropped during the latency window: no acknowledge at all.
    @(negedge clk);
    b           = n_ack;
    readAddress = 24'h000040;
    read        = 1'b1;
    @(negedge clk);
    read = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_ack", n_ack - b, 0);
    read_burst(24'h000041, 16'h5001, 2, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion required completion");
    $fatal(1, "timeout");
  end

endmodule
